cmd_exec_ctrl: RTL and testbench

Command sequencer that drives the 4x8-bit register file's write, writeback and read-select interface. It accepts 8-bit command words over a valid/ready handshake and decodes them. It sequences register reads through the RA/X path, computes with an internal 8-bit ALU, and commits results through the res_alu/res_dest/enact writeback port or the DATA_INPUT load port. It sits between the command source (switches or command memory) and the register file.

---
 rtl/cmd_exec_ctrl_pkg.sv | 32 +++
 rtl/cmd_exec_ctrl_if.sv | 28 ++
 rtl/cmd_exec_ctrl_alu.sv | 36 +++
 rtl/cmd_exec_ctrl.sv | 124 ++++++++++++
 tb/tb_cmd_exec_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_exec_ctrl_pkg.sv
// Shared opcodes, state encoding and command field positions
// for the register-file command sequencer.
package cmd_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd1;
  localparam logic [3:0] OP_MOV = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;
  localparam int DST_HI = 3;
  localparam int DST_LO = 2;
  localparam int SRC_HI = 1;
  localparam int SRC_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IMM,
    S_LOAD,
    S_RDA,
    S_RDB,
    S_EXE,
    S_WB
  } state_e;

endpackage

// File: rtl/cmd_exec_ctrl_if.sv
// Command handshake plus register file read/load/writeback port.
interface cmd_exec_ctrl_if #(
    parameter int DW = 8
) ();
    logic [DW-1:0] cmd_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] rf_x;
    logic [1:0]    rf_ra;
    logic          rf_rd;
    logic          rf_wr;
    logic [DW-1:0] rf_data;
    logic [DW-1:0] rf_res_alu;
    logic [1:0]    rf_res_dest;
    logic          rf_enact;

    modport master (
        input  cmd_data, cmd_valid, rf_x,
        output cmd_ready, rf_ra, rf_rd, rf_wr,
        output rf_data, rf_res_alu, rf_res_dest, rf_enact
    );

    modport slave (
        output cmd_data, cmd_valid, rf_x,
        input  cmd_ready, rf_ra, rf_rd, rf_wr,
        input  rf_data, rf_res_alu, rf_res_dest, rf_enact
    );
endinterface

// File: rtl/cmd_exec_ctrl_alu.sv
// Combinational 8-bit ALU; SUB carry is the borrow (opa < opb).
module cmd_alu
    import cmd_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    opc,
    input  logic [DW-1:0] opa,
    input  logic [DW-1:0] opb,
    output logic [DW-1:0] res,
    output logic          c,
    output logic          z
);
    logic [DW:0] sum;
    logic [DW:0] diff;

    assign sum  = {1'b0, opa} + {1'b0, opb};
    assign diff = {1'b0, opa} - {1'b0, opb};

    always_comb begin
        res = '0;
        c   = 1'b0;
        unique case (opc)
            OP_MOV:  res = opb;
            OP_ADD:  {c, res} = sum;
            OP_SUB:  {c, res} = diff;
            OP_AND:  res = opa & opb;
            OP_OR:   res = opa | opb;
            OP_XOR:  res = opa ^ opb;
            OP_NOT:  res = ~opa;
            default: res = '0;
        endcase
    end

    assign z = (res == '0);
endmodule

// File: rtl/cmd_exec_ctrl.sv
// Command sequencer: decode, read dst/src through RA/X, execute,
// then commit via writeback or the DATA_INPUT load port.
module cmd_exec_ctrl
    import cmd_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic clk,
    input  logic rst,
    cmd_exec_ctrl_if.master bus,
    output logic busy,
    output logic done,
    output logic err,
    output logic flag_z,
    output logic flag_c
);
    state_e        state, state_n;
    logic [DW-1:0] cmd_r;
    logic [DW-1:0] imm;
    logic [DW-1:0] opa;
    logic [DW-1:0] res_r;
    logic          nop_done;
    logic          accept;
    logic [3:0]    opc_in;
    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic          alu_z;

    assign opc_in = bus.cmd_data[OPC_HI:OPC_LO];
    assign accept = bus.cmd_valid & bus.cmd_ready;

    // X already carries R[src] during EXE, so opb feeds the ALU directly
    cmd_alu #(.DW(DW)) u_alu (
        .opc (cmd_r[OPC_HI:OPC_LO]),
        .opa (opa),
        .opb (bus.rf_x),
        .res (alu_res),
        .c   (alu_c),
        .z   (alu_z)
    );

    always_comb begin
        state_n         = state;
        bus.cmd_ready   = 1'b0;
        bus.rf_ra       = 2'd0;
        bus.rf_rd       = 1'b0;
        bus.rf_wr       = 1'b0;
        bus.rf_data     = '0;
        bus.rf_res_alu  = '0;
        bus.rf_res_dest = 2'd0;
        bus.rf_enact    = 1'b1;
        unique case (state)
            S_IDLE: begin
                bus.cmd_ready = ~rst;
                if (accept) begin
                    unique case (1'b1)
                        (opc_in == OP_LDI): state_n = S_IMM;
                        (opc_in >= OP_MOV && opc_in <= OP_NOT):
                            state_n = S_RDA;
                        default: state_n = S_IDLE;
                    endcase
                end
            end
            S_IMM: begin
                bus.cmd_ready = ~rst;
                if (accept) state_n = S_LOAD;
            end
            S_LOAD: begin
                bus.rf_ra   = cmd_r[DST_HI:DST_LO];
                bus.rf_data = imm;
                bus.rf_rd   = 1'b1;
                state_n     = S_IDLE;
            end
            S_RDA: begin
                bus.rf_ra = cmd_r[DST_HI:DST_LO];
                state_n   = S_RDB;
            end
            S_RDB: begin
                bus.rf_ra = cmd_r[SRC_HI:SRC_LO];
                state_n   = S_EXE;
            end
            S_EXE: state_n = S_WB;
            S_WB: begin
                bus.rf_res_alu  = res_r;
                bus.rf_res_dest = cmd_r[DST_HI:DST_LO];
                bus.rf_enact    = 1'b0;
                state_n         = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cmd_r    <= '0;
            imm      <= '0;
            opa      <= '0;
            res_r    <= '0;
            nop_done <= 1'b0;
            err      <= 1'b0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
        end else begin
            state    <= state_n;
            nop_done <= 1'b0;
            if (state == S_IDLE && accept) begin
                cmd_r <= bus.cmd_data;
                if (opc_in == OP_NOP) nop_done <= 1'b1;
                if (opc_in > OP_NOT) err <= 1'b1;
            end
            if (state == S_IMM && accept) imm <= bus.cmd_data;
            if (state == S_RDB) opa <= bus.rf_x;
            if (state == S_EXE) begin
                res_r  <= alu_res;
                flag_z <= alu_z;
                flag_c <= alu_c;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = nop_done | (state == S_LOAD) | (state == S_WB);
endmodule

// File: tb/tb_cmd_exec_ctrl.sv
// Directed bench for cmd_exec_ctrl with a behavioural 4x8 register file.
module tb_cmd_exec_ctrl;
    logic clk;
    logic rst;
    logic busy, done, err, flag_z, flag_c;
    int   errors = 0;
    int   checks = 0;
    int   acc_cnt = 0;
    int   rd_cnt = 0;
    int   wb_cnt = 0;
    int   snap_a, snap_r, snap_w;
    logic [7:0] R [4];

    cmd_exec_ctrl_if #(.DW(8)) ifc ();

    cmd_exec_ctrl #(.DW(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (ifc.master),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .flag_z (flag_z),
        .flag_c (flag_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: registered X read, DATA_INPUT load, writeback
    always @(posedge clk) begin
        if (rst) begin
            R <= '{default: 8'h00};
            ifc.rf_x <= 8'h00;
        end else begin
            ifc.rf_x <= R[ifc.rf_ra];
            if (ifc.rf_rd && !ifc.rf_wr) R[ifc.rf_ra] <= ifc.rf_data;
            if (!ifc.rf_enact) R[ifc.rf_res_dest] <= ifc.rf_res_alu;
        end
    end

    always @(posedge clk) begin
        if (ifc.cmd_valid && ifc.cmd_ready && !rst) acc_cnt++;
        if (ifc.rf_rd) rd_cnt++;
        if (!ifc.rf_enact) wb_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        int n = 0;
        ifc.cmd_data  = w;
        ifc.cmd_valid = 1'b1;
        @(negedge clk);
        while (!ifc.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", ifc.cmd_ready, 1);
        step();
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic ldi(input logic [1:0] r, input logic [7:0] v);
        send({4'h1, r, 2'b00});
        send(v);
        step();
    endtask

    task automatic alu_wb(input string tag, input logic [3:0] op,
                          input logic [1:0] d, input logic [1:0] s,
                          input logic [7:0] er, input logic ec,
                          input logic ez);
        send({op, d, s});
        repeat (3) step();
        chk({tag, "_enact"}, ifc.rf_enact, 0);
        chk({tag, "_dest"}, ifc.rf_res_dest, d);
        chk({tag, "_res"}, ifc.rf_res_alu, er);
        chk({tag, "_c"}, flag_c, ec);
        chk({tag, "_z"}, flag_z, ez);
        chk({tag, "_done"}, done, 1);
        step();
        chk({tag, "_rf"}, R[d], er);
    endtask

    initial begin
        rst = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_data = 8'h00;
        repeat (2) step();
        chk("rst_ready", ifc.cmd_ready, 0);
        chk("rst_ra", ifc.rf_ra, 0);
        chk("rst_rd", ifc.rf_rd, 0);
        chk("rst_wr", ifc.rf_wr, 0);
        chk("rst_data", ifc.rf_data, 0);
        chk("rst_res", ifc.rf_res_alu, 0);
        chk("rst_dest", ifc.rf_res_dest, 0);
        chk("rst_enact", ifc.rf_enact, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_fz", flag_z, 0);
        chk("rst_fc", flag_c, 0);
        rst = 1'b0;
        #1;
        chk("idle_ready", ifc.cmd_ready, 1);

        // LDI R2, 0x5A
        send(8'h18);
        chk("imm_busy", busy, 1);
        chk("imm_ready", ifc.cmd_ready, 1);
        send(8'h5A);
        chk("load_ra", ifc.rf_ra, 2);
        chk("load_rd", ifc.rf_rd, 1);
        chk("load_wr", ifc.rf_wr, 0);
        chk("load_data", ifc.rf_data, 8'h5A);
        chk("load_enact", ifc.rf_enact, 1);
        chk("load_done", done, 1);
        chk("load_ready", ifc.cmd_ready, 0);
        step();
        chk("load_rf", R[2], 8'h5A);
        chk("load_done_off", done, 0);

        // ADD R0,R1 with carry, explicit RA sequence
        ldi(2'd0, 8'hF0);
        ldi(2'd1, 8'h20);
        send(8'h31);
        chk("add_rda_ra", ifc.rf_ra, 0);
        chk("add_rda_rdy", ifc.cmd_ready, 0);
        step();
        chk("add_rdb_ra", ifc.rf_ra, 1);
        step();
        chk("add_exe_enact", ifc.rf_enact, 1);
        step();
        chk("add_wb_enact", ifc.rf_enact, 0);
        chk("add_wb_dest", ifc.rf_res_dest, 0);
        chk("add_wb_res", ifc.rf_res_alu, 8'h10);
        chk("add_wb_c", flag_c, 1);
        chk("add_wb_z", flag_z, 0);
        chk("add_wb_done", done, 1);
        step();
        chk("add_rf", R[0], 8'h10);
        chk("add_after_enact", ifc.rf_enact, 1);

        // SUB self and SUB with borrow
        ldi(2'd3, 8'h33);
        alu_wb("sub_self", 4'h4, 2'd3, 2'd3, 8'h00, 1'b0, 1'b1);
        ldi(2'd0, 8'h05);
        ldi(2'd1, 8'h07);
        alu_wb("sub_borrow", 4'h4, 2'd0, 2'd1, 8'hFE, 1'b1, 1'b0);
        alu_wb("xor_self", 4'h7, 2'd1, 2'd1, 8'h00, 1'b0, 1'b1);
        ldi(2'd1, 8'h07);
        alu_wb("not_r0", 4'h8, 2'd0, 2'd3, 8'h01, 1'b0, 1'b0);
        alu_wb("mov_r3", 4'h2, 2'd3, 2'd1, 8'h07, 1'b0, 1'b0);

        // IMM waits indefinitely for the immediate
        send(8'h18);
        repeat (10) step();
        chk("immwait_busy", busy, 1);
        chk("immwait_ready", ifc.cmd_ready, 1);
        send(8'h77);
        step();
        chk("immwait_rf", R[2], 8'h77);

        // Back-to-back ADD stream with valid held high
        ldi(2'd0, 8'h01);
        ldi(2'd1, 8'h02);
        snap_a = acc_cnt;
        ifc.cmd_data = 8'h31;
        ifc.cmd_valid = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("stream_ready_lo", ifc.cmd_ready, 0);
            step();
        end
        chk("stream_ready_hi", ifc.cmd_ready, 1);
        chk("stream_rf1", R[0], 8'h03);
        step();
        ifc.cmd_valid = 1'b0;
        repeat (4) step();
        chk("stream_rf2", R[0], 8'h05);
        chk("stream_acc", acc_cnt - snap_a, 2);

        // Illegal opcode then NOP
        snap_r = rd_cnt;
        snap_w = wb_cnt;
        send(8'h90);
        chk("ill_err", err, 1);
        chk("ill_busy", busy, 0);
        repeat (2) step();
        send(8'h00);
        chk("nop_done", done, 1);
        chk("nop_busy", busy, 0);
        step();
        chk("nop_done_off", done, 0);
        chk("ill_rd_cnt", rd_cnt, snap_r);
        chk("ill_wb_cnt", wb_cnt, snap_w);
        alu_wb("post_ill", 4'h3, 2'd0, 2'd1, 8'h07, 1'b0, 1'b0);
        chk("err_sticky", err, 1);

        // Reset during EXE aborts the commit
        snap_w = wb_cnt;
        send(8'h31);
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("mrst_enact", ifc.rf_enact, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_err", err, 0);
        chk("mrst_ready", ifc.cmd_ready, 0);
        chk("mrst_fc", flag_c, 0);
        chk("mrst_wb_cnt", wb_cnt, snap_w);
        rst = 1'b0;
        #1;
        chk("mrst_idle_ready", ifc.cmd_ready, 1);
        ldi(2'd0, 8'h07);
        ldi(2'd1, 8'h02);
        alu_wb("post_rst", 4'h3, 2'd0, 2'd1, 8'h09, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
